// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_REQ,
      S_NEXT,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   // Word index width; a single-word fetch still needs one bit.
   function automatic int calc_idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/ifetch_wdog.sv
// Memory wait watchdog: counts consecutive stalled REQ cycles and flags expiry
// on the TIMEOUT-th one so the controller can leave REQ on that edge.
module ifetch_wdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expire = en && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ifetch_ctrl.sv
// Multi-word instruction fetch controller over an MFC-handshake memory.
// Optional memory-timeout fault enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int WORDS   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    flush,
   input  logic [ADDR_W-1:0]       pc_in,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_en,
   output logic                    mem_rw,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mfc,
   output logic [WORDS*DATA_W-1:0] ir,
   output logic                    ir_valid,
   output logic [ADDR_W-1:0]       pc_next,
   output logic                    busy,
   output logic                    fault
);

   localparam int IDX_W = calc_idx_w(WORDS);

   if (WORDS < 1 || WORDS > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("ifetch_ctrl: WORDS must be 1..4 and TIMEOUT 1..255");
   end

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_base;
   logic [IDX_W-1:0]  idx;
   logic              last_word;
   logic              wd_expire;

   assign last_word = (idx == IDX_W'(WORDS - 1));

`ifdef IFETCH_TIMEOUT_EN
   ifetch_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    ((state != S_REQ) || mfc || flush),
      .en     ((state == S_REQ) && !mfc),
      .expire (wd_expire)
   );
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // flush has the last word so it overrides mfc and start
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ADDR;
         S_ADDR:  state_nxt = S_REQ;
         S_REQ: begin
            if (mfc)            state_nxt = S_NEXT;
            else if (wd_expire) state_nxt = S_FAULT;
         end
         S_NEXT:  state_nxt = last_word ? S_DONE : S_ADDR;
         S_DONE:  state_nxt = S_IDLE;
         S_FAULT: if (start) state_nxt = S_ADDR;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_base  <= '0;
         idx      <= '0;
         mem_addr <= '0;
         ir       <= '0;
         pc_next  <= '0;
      end else if (!flush) begin
         case (state)
            S_IDLE, S_FAULT: begin
               if (start) begin
                  pc_base <= pc_in;
                  idx     <= '0;
               end
            end
            S_ADDR: mem_addr <= pc_base + ADDR_W'(idx);
            S_REQ: begin
               if (mfc) ir[int'(idx)*DATA_W +: DATA_W] <= mem_rdata;
            end
            S_NEXT: begin
               if (last_word) pc_next <= pc_base + ADDR_W'(WORDS);
               else           idx     <= idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign mem_en   = (state == S_REQ);
   assign mem_rw   = (state == S_REQ) ? MEM_READ : MEM_WRITE;
   assign ir_valid = (state == S_DONE);
   assign busy     = (state == S_ADDR) || (state == S_REQ) ||
                     (state == S_NEXT) || (state == S_DONE);
   assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl (WORDS=2); timeout section depends on IFETCH_TIMEOUT_EN.
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] pc_in = '0;
   logic [15:0] mem_addr;
   logic        mem_en;
   logic        mem_rw;
   logic [15:0] mem_rdata = '0;
   logic        mfc = 1'b0;
   logic [31:0] ir;
   logic        ir_valid;
   logic [15:0] pc_next;
   logic        busy;
   logic        fault;

   int total = 0;
   int bad   = 0;

   ifetch_ctrl #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .WORDS   (2),
      .TIMEOUT (15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .flush     (flush),
      .pc_in     (pc_in),
      .mem_addr  (mem_addr),
      .mem_en    (mem_en),
      .mem_rw    (mem_rw),
      .mem_rdata (mem_rdata),
      .mfc       (mfc),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .pc_next   (pc_next),
      .busy      (busy),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a fetch and plays a memory that answers word w after dly_w stalls.
   // Returns in the ir_valid cycle (cycle numbers count from the start edge).
   task automatic run_fetch(input logic [15:0] pc, input logic [15:0] d0, input logic [15:0] d1,
                            input int dly0, input int dly1, output int vcyc,
                            output logic [15:0] a0, output logic [15:0] a1,
                            output logic stable);
      int w;
      int cnt;
      w = 0; cnt = 0; vcyc = -1; stable = 1'b1; a0 = '1; a1 = '1;
      start = 1'b1; pc_in = pc;
      step();
      start = 1'b0;
      for (int k = 1; k <= 60 && vcyc < 0; k++) begin
         mfc = 1'b0;
         if (ir_valid) begin
            vcyc = k;
         end else if (mem_en) begin
            if (cnt == 0) begin
               if (w == 0) a0 = mem_addr; else a1 = mem_addr;
            end else if (mem_addr != ((w == 0) ? a0 : a1)) begin
               stable = 1'b0;
            end
            if (cnt == ((w == 0) ? dly0 : dly1)) begin
               mfc = 1'b1;
               mem_rdata = (w == 0) ? d0 : d1;
               cnt = 0;
               w++;
            end else begin
               cnt++;
            end
         end
         if (vcyc < 0) step();
      end
      mfc = 1'b0;
   endtask

   initial begin
      int          vcyc;
      int          fcyc;
      logic [15:0] a0, a1;
      logic        stable;
      logic        seen_valid;

      // Reset state
      #2;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_rw", mem_rw, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_outs", {mem_addr, ir, pc_next}, 0);
      step();
      step();
      rst = 1'b1;
      step();

      // Zero-wait fetch
      run_fetch(16'h0040, 16'h1234, 16'hABCD, 0, 0, vcyc, a0, a1, stable);
      chk("zw_vcyc", vcyc, 7);
      chk("zw_addr0", a0, 16'h0040);
      chk("zw_addr1", a1, 16'h0041);
      chk("zw_ir", ir, 32'hABCD1234);
      chk("zw_pc_next", pc_next, 16'h0042);
      chk("zw_busy_done", busy, 1);
      step();
      chk("zw_idle", {busy, ir_valid}, 0);

      // Word 1 answered after four stalls
      run_fetch(16'h0300, 16'h1111, 16'h2222, 0, 4, vcyc, a0, a1, stable);
      chk("dly_vcyc", vcyc, 11);
      chk("dly_addr1", a1, 16'h0301);
      chk("dly_stable", stable, 1);
      chk("dly_ir", ir, 32'h22221111);
      chk("dly_pc_next", pc_next, 16'h0302);

      // Back-to-back: start held through the DONE->IDLE cycle
      start = 1'b1; pc_in = 16'h0700;
      step();
      chk("b2b_idle_busy", busy, 0);
      step();
      start = 1'b0;
      chk("b2b_addr_busy", busy, 1);
      step();
      chk("b2b_req_addr", mem_addr, 16'h0700);
      chk("b2b_req_en", {mem_en, mem_rw}, 2'b11);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("b2b_flushed", busy, 0);

      // Asynchronous reset while in REQ
      start = 1'b1; pc_in = 16'h0020;
      step();
      start = 1'b0;
      step();
      chk("arst_in_req", mem_en, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_ctrl", {mem_en, mem_rw, busy, fault, ir_valid}, 0);
      chk("arst_regs", {mem_addr, ir, pc_next}, 0);
      step();
      rst = 1'b1;
      seen_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (ir_valid || busy) seen_valid = 1'b1;
      end
      chk("arst_stays_idle", seen_valid, 0);

      // Address wrap
      run_fetch(16'hFFFF, 16'hBEEF, 16'hCAFE, 0, 0, vcyc, a0, a1, stable);
      chk("wrap_addr0", a0, 16'hFFFF);
      chk("wrap_addr1", a1, 16'h0000);
      chk("wrap_pc_next", pc_next, 16'h0001);
      chk("wrap_ir", ir, 32'hCAFEBEEF);
      step();

      // Flush against mfc on the last word; start while busy ignored
      start = 1'b1; pc_in = 16'h0200;
      step();
      start = 1'b0;
      step();
      chk("fl_addr0", mem_addr, 16'h0200);
      start = 1'b1; pc_in = 16'h0900; mfc = 1'b1; mem_rdata = 16'h5555;
      step();
      start = 1'b0; mfc = 1'b0;
      step();
      step();
      chk("fl_addr1_ignores_start", mem_addr, 16'h0201);
      chk("fl_req", mem_en, 1);
      mfc = 1'b1; flush = 1'b1; start = 1'b1; mem_rdata = 16'h7777;
      step();
      mfc = 1'b0; flush = 1'b0; start = 1'b0;
      chk("fl_idle", {busy, mem_en, ir_valid}, 0);
      chk("fl_ir_kept", ir, 32'hCAFE5555);
      seen_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (ir_valid || busy) seen_valid = 1'b1;
      end
      chk("fl_no_valid", seen_valid, 0);

      // Memory that never answers
      start = 1'b1; pc_in = 16'h0500;
      step();
      start = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      fcyc = -1;
      for (int k = 1; k <= 40 && fcyc < 0; k++) begin
         if (fault) fcyc = k;
         else step();
      end
      chk("to_fault_cycle", fcyc, 17);
      chk("to_mem_idle", {mem_en, busy}, 0);
      run_fetch(16'h0100, 16'hAAAA, 16'h5555, 0, 0, vcyc, a0, a1, stable);
      chk("to_retry_vcyc", vcyc, 7);
      chk("to_retry_addr0", a0, 16'h0100);
      chk("to_retry_ir", ir, 32'h5555AAAA);
      chk("to_retry_pc_next", pc_next, 16'h0102);
      chk("to_fault_clear", fault, 0);
      step();
`else
      fcyc = 0;
      for (int k = 1; k <= 25; k++) begin
         step();
         if (fault) fcyc++;
      end
      chk("nto_no_fault", fcyc, 0);
      chk("nto_still_req", {mem_en, busy}, 2'b11);
      chk("nto_addr_held", mem_addr, 16'h0500);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("nto_flushed", busy, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
